// File: rtl/pong_match_sequencer.sv
// pong_match_sequencer: match-level controller for Pong (idle, serve, rally, point, over).
// Define PONG_PAUSE_EN to add a pause input that freezes SERVE, RALLY and POINT.
module pong_match_sequencer #(
  parameter int WIN_SCORE    = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PONG_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       player_scored,
  input  logic       cpu_scored,
  output logic       ball_reset,
  output logic       ball_launch,
  output logic       serve_dir,
  output logic       paddles_en,
  output logic [2:0] player_score,
  output logic [2:0] cpu_score,
  output logic       player_win,
  output logic       cpu_win,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [6:0] SERVE_LAST = 7'(SERVE_FRAMES - 1);
  localparam logic [6:0] POINT_LAST = 7'(POINT_FRAMES - 1);
  localparam logic [2:0] WIN        = 3'(WIN_SCORE);

  state_t     st;
  logic [6:0] frame_cnt;
  logic       player_prev;
  logic       cpu_prev;
  logic       start_prev;
  logic       paddles_q;
  logic       frozen;
  logic       player_edge;
  logic       cpu_edge;
  logic       start_edge;
  logic       serve_done;
  logic       point_done;

`ifdef PONG_PAUSE_EN
  assign frozen = pause && (st == S_SERVE || st == S_RALLY || st == S_POINT);
`else
  assign frozen = 1'b0;
`endif

  assign player_edge = player_scored && !player_prev;
  assign cpu_edge    = cpu_scored && !cpu_prev;
  assign start_edge  = start_btn && !start_prev;
  assign serve_done  = (st == S_SERVE) && frame_tick && (frame_cnt == SERVE_LAST) && !frozen;
  assign point_done  = (st == S_POINT) && frame_tick && (frame_cnt == POINT_LAST) && !frozen;

  // Launch is decoded so it lines up with the tick that ends the serve countdown.
  assign ball_launch = serve_done && !rst;
  assign paddles_en  = paddles_q && !frozen;
  assign state       = st;

  always_ff @(posedge clk) begin
    // Edge-detect history always tracks the inputs, so a level held across a pause
    // or a reset never produces a late edge.
    player_prev <= player_scored;
    cpu_prev    <= cpu_scored;
    start_prev  <= start_btn;
    if (rst) begin
      st           <= S_IDLE;
      frame_cnt    <= '0;
      player_score <= '0;
      cpu_score    <= '0;
      player_win   <= 1'b0;
      cpu_win      <= 1'b0;
      serve_dir    <= 1'b0;
      ball_reset   <= 1'b1;
      paddles_q    <= 1'b0;
    end else if (!frozen) begin
      case (st)
        S_IDLE: begin
          if (start_btn) begin
            st           <= S_SERVE;
            frame_cnt    <= '0;
            player_score <= '0;
            cpu_score    <= '0;
            player_win   <= 1'b0;
            cpu_win      <= 1'b0;
            ball_reset   <= 1'b1;
            paddles_q    <= 1'b1;
          end
        end
        S_SERVE: begin
          if (serve_done) begin
            st         <= S_RALLY;
            frame_cnt  <= '0;
            ball_reset <= 1'b0;
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 7'd1;
          end
        end
        S_RALLY: begin
          if (player_edge || cpu_edge) begin
            st         <= S_POINT;
            frame_cnt  <= '0;
            ball_reset <= 1'b1;
            paddles_q  <= 1'b0;
            // Simultaneous edges replay the serve: no score, direction kept.
            if (player_edge && !cpu_edge) begin
              if (player_score != WIN) player_score <= player_score + 3'd1;
              serve_dir <= 1'b0;
            end else if (cpu_edge && !player_edge) begin
              if (cpu_score != WIN) cpu_score <= cpu_score + 3'd1;
              serve_dir <= 1'b1;
            end
          end
        end
        S_POINT: begin
          if (point_done) begin
            frame_cnt <= '0;
            if (player_score == WIN) begin
              player_win <= 1'b1;
              st         <= S_OVER;
            end else if (cpu_score == WIN) begin
              cpu_win <= 1'b1;
              st      <= S_OVER;
            end else begin
              st        <= S_SERVE;
              paddles_q <= 1'b1;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 7'd1;
          end
        end
        S_OVER: begin
          if (start_edge) begin
            st           <= S_SERVE;
            frame_cnt    <= '0;
            player_score <= '0;
            cpu_score    <= '0;
            player_win   <= 1'b0;
            cpu_win      <= 1'b0;
            serve_dir    <= 1'b0;
            ball_reset   <= 1'b1;
            paddles_q    <= 1'b1;
          end
        end
        default: begin
          st         <= S_IDLE;
          frame_cnt  <= '0;
          ball_reset <= 1'b1;
          paddles_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
